// File: rtl/gate_vector_sequencer.sv
// Sweeps every input vector onto a combinational gate-under-test, checks its output
// against an expected truth table and reports mismatch count, first failing vector and pass.
module gate_vector_sequencer #(
  parameter int                      N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]    TRUTH  = 4'b0111,
  parameter int                      SETTLE = 0,
  parameter int                      ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   vec,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              first_err_valid,
  output logic [N_IN-1:0]   first_err_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
  localparam logic [7:0]      SETTLE_V = 8'(SETTLE);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [N_IN-1:0]   vec_nxt, first_err_vec_nxt;
  logic [ERR_W-1:0]  err_cnt_nxt;
  logic              busy_nxt, done_nxt, pass_nxt, first_err_valid_nxt;
  logic              mismatch;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      vec             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      vec             <= vec_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      pass            <= pass_nxt;
      err_cnt         <= err_cnt_nxt;
      first_err_valid <= first_err_valid_nxt;
      first_err_vec   <= first_err_vec_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    cnt_nxt             = cnt;
    vec_nxt             = vec;
    busy_nxt            = busy;
    done_nxt            = done;
    pass_nxt            = pass;
    err_cnt_nxt         = err_cnt;
    first_err_valid_nxt = first_err_valid;
    first_err_vec_nxt   = first_err_vec;
    mismatch            = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          vec_nxt             = '0;
          cnt_nxt             = SETTLE_V;
          err_cnt_nxt         = '0;
          first_err_valid_nxt = 1'b0;
          first_err_vec_nxt   = '0;
          done_nxt            = 1'b0;
          pass_nxt            = 1'b0;
          busy_nxt            = 1'b1;
          state_nxt           = RUN;
        end
      end
      RUN: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          // Gate output has settled for this vector: sample and score it.
          mismatch = (y_in != TRUTH[vec]);
          if (mismatch) begin
            err_cnt_nxt = sat_inc(err_cnt);
            if (!first_err_valid) begin
              first_err_valid_nxt = 1'b1;
              first_err_vec_nxt   = vec;
            end
          end
          if (vec == LAST_VEC) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_cnt_nxt == '0);
          end else begin
            vec_nxt = vec + N_IN'(1);
            cnt_nxt = SETTLE_V;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench: NOT-from-NAND (good and faulty), 2-input NAND with settle delay,
// 1-bit saturating error counter, start-while-busy, mid-run reset and back-to-back runs.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start1, start2, start3, fault1, fault2;

  logic [0:0] vec1, fev_vec1;
  logic [7:0] err1;
  logic       y1, busy1, done1, pass1, fev1;

  logic [1:0] vec2, fev_vec2;
  logic [7:0] err2;
  logic       y2, busy2, done2, pass2, fev2;

  logic [1:0] vec3, fev_vec3;
  logic [0:0] err3;
  logic       y3, busy3, done3, pass3, fev3;

  // Gates under test: NOT (or a buffer when faulty), NAND (or AND when faulty), stuck-inverted NAND.
  assign y1 = fault1 ? vec1[0] : ~vec1[0];
  assign y2 = fault2 ? (vec2[1] & vec2[0]) : ~(vec2[1] & vec2[0]);
  assign y3 = vec3[1] & vec3[0];

  gate_vector_sequencer #(.N_IN(1), .TRUTH(2'b01), .SETTLE(0), .ERR_W(8)) u_not (
    .clk(clk), .rst_n(rst_n), .start(start1), .vec(vec1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_valid(fev1), .first_err_vec(fev_vec1));

  gate_vector_sequencer #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(2), .ERR_W(8)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec(vec2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .first_err_valid(fev2), .first_err_vec(fev_vec2));

  gate_vector_sequencer #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(0), .ERR_W(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start3), .vec(vec3), .y_in(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .first_err_valid(fev3), .first_err_vec(fev_vec3));

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    fault1 = 1'b0;
    fault2 = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_vec",   32'(vec1),     32'd0);
    chk("rst_busy",  32'(busy1),    32'd0);
    chk("rst_done",  32'(done1),    32'd0);
    chk("rst_pass",  32'(pass1),    32'd0);
    chk("rst_err",   32'(err1),     32'd0);
    chk("rst_fev",   32'(fev1),     32'd0);
    chk("rst_fvec",  32'(fev_vec1), 32'd0);
    chk("rst_busy2", 32'(busy2),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct NOT gate
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    chk("not_vec0",  32'(vec1),  32'd0);
    chk("not_busy",  32'(busy1), 32'd1);
    chk("not_done0", 32'(done1), 32'd0);
    @(negedge clk);
    chk("not_vec1",  32'(vec1),  32'd1);
    chk("not_done1", 32'(done1), 32'd0);
    @(negedge clk);
    chk("not_done",  32'(done1), 32'd1);
    chk("not_pass",  32'(pass1), 32'd1);
    chk("not_err",   32'(err1),  32'd0);
    chk("not_fev",   32'(fev1),  32'd0);
    chk("not_idle",  32'(busy1), 32'd0);
    chk("not_vecL",  32'(vec1),  32'd1);

    // Faulty NOT (buffer), started from DONE
    fault1 = 1'b1;
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    chk("buf_clr_done", 32'(done1), 32'd0);
    chk("buf_clr_pass", 32'(pass1), 32'd0);
    chk("buf_busy",     32'(busy1), 32'd1);
    repeat (2) @(negedge clk);
    chk("buf_err",  32'(err1),     32'd2);
    chk("buf_fev",  32'(fev1),     32'd1);
    chk("buf_fvec", 32'(fev_vec1), 32'd0);
    chk("buf_pass", 32'(pass1),    32'd0);
    chk("buf_done", 32'(done1),    32'd1);

    // Back-to-back: correct gate reconnected, start in DONE
    fault1 = 1'b0;
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    chk("b2b_clr_err", 32'(err1),  32'd0);
    chk("b2b_clr_fev", 32'(fev1),  32'd0);
    chk("b2b_clr_done",32'(done1), 32'd0);
    repeat (2) @(negedge clk);
    chk("b2b_pass", 32'(pass1), 32'd1);
    chk("b2b_err",  32'(err1),  32'd0);
    chk("b2b_done", 32'(done1), 32'd1);

    // NAND with SETTLE=2: each vector held 3 cycles, done 12 cycles after start
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("nand_vec",  32'(vec2),  32'(k / 3));
      chk("nand_busy", 32'(busy2), 32'd1);
      chk("nand_done", 32'(done2), 32'd0);
      @(negedge clk);
    end
    chk("nand_doneE", 32'(done2), 32'd1);
    chk("nand_idle",  32'(busy2), 32'd0);
    chk("nand_pass",  32'(pass2), 32'd1);
    chk("nand_err",   32'(err2),  32'd0);
    chk("nand_vecL",  32'(vec2),  32'd3);

    // 1-bit error counter saturates rather than wrapping
    start3 = 1'b1; @(negedge clk); start3 = 1'b0;
    chk("sat_err0", 32'(err3), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("sat_err", 32'(err3), 32'd1);
      chk("sat_fev", 32'(fev3), 32'd1);
    end
    chk("sat_done", 32'(done3),    32'd1);
    chk("sat_pass", 32'(pass3),    32'd0);
    chk("sat_fvec", 32'(fev_vec3), 32'd0);

    // start re-pulsed while busy, then reset mid-run
    fault2 = 1'b1;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    chk("rep_busy", 32'(busy2), 32'd1);
    chk("rep_vec0", 32'(vec2),  32'd0);
    repeat (2) @(negedge clk);
    chk("rep_vec1", 32'(vec2), 32'd1);
    chk("rep_err",  32'(err2), 32'd1);
    chk("rep_fev",  32'(fev2), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy", 32'(busy2), 32'd0);
    chk("mrst_done", 32'(done2), 32'd0);
    chk("mrst_vec",  32'(vec2),  32'd0);
    chk("mrst_err",  32'(err2),  32'd0);
    chk("mrst_fev",  32'(fev2),  32'd0);
    chk("mrst_pass", 32'(pass2), 32'd0);

    // Clean full sweep after reset
    fault2 = 1'b0;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    repeat (11) @(negedge clk);
    chk("post_done_early", 32'(done2), 32'd0);
    chk("post_busy",       32'(busy2), 32'd1);
    @(negedge clk);
    chk("post_done", 32'(done2), 32'd1);
    chk("post_pass", 32'(pass2), 32'd1);
    chk("post_err",  32'(err2),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
- Self-checking stimulus/response stage for the gate-conversion blocks (NOT/AND/OR/XOR built from NAND/NOR).
- Sits directly upstream of a combinational gate-under-test: it drives every input combination onto the gate inputs.
- It also sits downstream of the gate: it samples the gate output, compares it against an expected truth table, and reports a pass/fail summary.
- It replaces hand-written per-gate stimulus and makes gate checks synthesizable and repeatable.

Parameters:
- N_IN, 2: number of gate inputs (1..6); stimulus vector width.
- TRUTH, 4'b0111: expected-output table, width 2**N_IN; bit i = expected gate output for input vector i (default = 2-input NAND).
- SETTLE, 0: extra cycles each vector is held before sampling (0..255).
- ERR_W, 8: width of the mismatch counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle run request; honoured only when not busy
- vec  out  N_IN  stimulus to the gate-under-test inputs
- y_in  in  1  gate-under-test output (combinational from vec)
- busy  out  1  run in progress
- done  out  1  run complete; held until next start or reset
- pass  out  1  done && err_cnt==0
- err_cnt  out  ERR_W  mismatch count, saturating
- first_err_valid  out  1  at least one mismatch seen in this run
- first_err_vec  out  N_IN  vector of the first mismatch in this run

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n, sampled on the rising edge of clk).
- Reset values: state=IDLE, vec=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_vec=0, settle counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge E:
  - vec<=0, cnt<=SETTLE;
  - err_cnt<=0, first_err_valid<=0, first_err_vec<=0;
  - done<=0, pass<=0, busy<=1;
  - state<=RUN.
- RUN, cnt!=0: cnt<=cnt-1; vec held.
- RUN, cnt==0: sample y_in at this edge and compare with TRUTH[vec].
  - On mismatch: err_cnt<=err_cnt+1, saturating at 2**ERR_W-1 (no wrap).
  - On mismatch with first_err_valid==0: first_err_vec<=vec and first_err_valid<=1.
  - If vec==2**N_IN-1: state<=DONE, busy<=0, done<=1. pass<=1 iff the final err_cnt (including this sample) is 0.
  - Otherwise: vec<=vec+1 and cnt<=SETTLE.
- Timing:
  - Each vector is held SETTLE+1 cycles.
  - done rises exactly 2**N_IN*(SETTLE+1) cycles after the start edge.
  - busy is high for exactly that many cycles.
- vec is never incremented past 2**N_IN-1; no wrap-around. In DONE, vec holds the last vector.
- start while busy: ignored, with no effect on state or counters.
- start in DONE: a fresh run. All results clear at that edge.
- Reset asserted mid-RUN: at that edge, return to IDLE with all reset values; partial results are discarded.
- y_in is sampled only at the cnt==0 edges of RUN; it is don't-care at all other times.

Test Plan:
- Correct NOT-from-NAND (N_IN=1, TRUTH=2'b01, SETTLE=0), start pulse:
  - vec=0 for 1 cycle, then vec=1 for 1 cycle;
  - done=1 two cycles after start, pass=1, err_cnt=0, first_err_valid=0.
- Faulty gate, a buffer instead of NOT (y=a), same config:
  - err_cnt=2, first_err_valid=1, first_err_vec=0, pass=0, done=1.
- NAND, N_IN=2, default TRUTH, SETTLE=2, correct gate:
  - vec steps 0,1,2,3, each held 3 cycles;
  - busy high for 12 cycles; done at start+12; pass=1.
- Saturation: ERR_W=1, N_IN=2, gate output stuck inverted:
  - err_cnt stops at 1 and does not wrap; first_err_vec=0; pass=0.
- start re-pulsed at cycle 1 of a run, then rst_n=0 asserted mid-run:
  - the second start has no effect; run length is unchanged;
  - after reset: busy=0, done=0, vec=0, err_cnt=0;
  - a new start runs a clean full sweep.
- Back-to-back runs: first run with a faulty gate, then a correct gate connected and start pulsed in DONE:
  - results cleared at the start edge;
  - second run ends with pass=1, err_cnt=0.
